// File: rtl/uart_mmio.sv
// uart_mmio: memory-mapped UART with TX FIFO drain, sticky overflow and host-polled RX
module uart_mmio #(
  parameter logic [63:0] BASE_ADDR = 64'h0000_0000_1000_0000,
  parameter int TX_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [7:0]  we,
  input  logic [63:0] addr,
  input  logic [63:0] wdata,
  output logic [63:0] rdata,
  output logic        uart_out_valid,
  output logic [7:0]  uart_out_ch,
  output logic        uart_in_valid,
  input  logic [7:0]  uart_in_ch
);
  localparam int AW = $clog2(TX_DEPTH);
  logic [7:0] mem [TX_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0] count;
  logic ovf, tx_en, hit, rd, push, pop, full, empty, accept;
  logic [1:0] off;
  logic [63:0] rd_val;
  logic unused_bits;
  assign unused_bits = ^{addr[2:0], wdata[63:8]};
  assign hit = en & (addr[63:5] == BASE_ADDR[63:5]);
  assign off = addr[4:3];
  assign rd = en & (we == 8'h0);
  assign empty = count == '0;
  assign full = count == (AW+1)'(TX_DEPTH);
  assign push = hit & we[0] & (off == 2'd0);
  assign pop = tx_en & ~empty;
  // a full FIFO still takes a byte when the head leaves in the same cycle
  assign accept = push & (~full | pop);
  assign uart_out_valid = pop;
  assign uart_out_ch = pop ? mem[rptr] : 8'h0;
  assign uart_in_valid = hit & rd & (off == 2'd2);
  // register read mux; status reflects state before this cycle's push/pop
  always_comb begin
    rd_val = off == 2'd1 ? {48'h0, 8'(count), 5'h0, ovf, empty, full} :
             off == 2'd2 ? {56'h0, uart_in_ch} :
             off == 2'd3 ? {63'h0, tx_en} : 64'h0;
  end
  // FIFO storage, written only when the push is accepted
  always_ff @(posedge clk) begin
    if (accept) mem[wptr] <= wdata[7:0];
  end
  // pointers, count, status/control flags and registered read data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
      ovf <= 1'b0;
      tx_en <= 1'b1;
      rdata <= 64'h0;
    end else begin
      if (accept) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      count <= count + (AW+1)'(accept) - (AW+1)'(pop);
      if (push & full & ~pop) ovf <= 1'b1;
      else if (hit & we[0] & (off == 2'd1) & wdata[2]) ovf <= 1'b0;
      if (hit & we[0] & (off == 2'd3)) tx_en <= wdata[0];
      if (rd) rdata <= hit ? rd_val : 64'h0;
    end
  end
endmodule

// File: tb/tb_uart_mmio.sv
// tb_uart_mmio: directed stimulus with queued expectations checked by a negedge monitor
module tb_uart_mmio;
  localparam logic [63:0] BASE = 64'h0000_0000_1000_0000;
  logic clk = 0, rst_n = 1, en = 0;
  logic [7:0] we = 0;
  logic [63:0] addr = 0, wdata = 0, rdata;
  logic uart_out_valid, uart_in_valid;
  logic [7:0] uart_out_ch;
  logic [7:0] uart_in_ch = 8'hFF;
  typedef struct {logic [7:0] ch; int cyc;} exp_t;
  exp_t exp_ch[$];
  exp_t e;
  logic [63:0] exp_rd[$];
  int errs = 0, checks = 0, cyc = 0, c;
  logic pend = 0;

  uart_mmio #(.BASE_ADDR(BASE), .TX_DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .uart_out_valid(uart_out_valid), .uart_out_ch(uart_out_ch),
    .uart_in_valid(uart_in_valid), .uart_in_ch(uart_in_ch)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic drive(logic e_i, logic [7:0] w, logic [63:0] a, logic [63:0] d);
    @(posedge clk); #1;
    en = e_i; we = w; addr = a; wdata = d;
  endtask

  task automatic wr(int off, logic [63:0] d, logic [7:0] w = 8'hFF);
    drive(1'b1, w, BASE + 64'(off * 8), d);
  endtask

  task automatic rd(logic [63:0] a, logic [63:0] x);
    drive(1'b1, 8'h0, a, 64'h0);
    exp_rd.push_back(x);
  endtask

  task automatic idle();
    drive(1'b0, 8'h0, 64'h0, 64'h0);
  endtask

  task automatic pushc(logic [7:0] ch, int cy);
    exp_ch.push_back('{ch, cy});
  endtask

  // monitor: read data one cycle after each read, emitted characters in order and on time
  always @(negedge clk) begin
    if (!rst_n) pend = 0;
    else begin
      if (pend) begin
        if (exp_rd.size() == 0) begin
          checks++; errs++;
          $display("FAIL rdata_extra: got %0h want none", rdata);
        end else chk("rdata", rdata, exp_rd.pop_front());
      end
      pend = en && we == 8'h0;
      if (uart_out_valid) begin
        if (exp_ch.size() == 0) begin
          checks++; errs++;
          $display("FAIL tx_extra: got %02h want none", uart_out_ch);
        end else begin
          e = exp_ch.pop_front();
          chk("tx_ch", uart_out_ch, e.ch);
          if (e.cyc >= 0) chk("tx_cycle", cyc, e.cyc);
        end
      end
    end
  end

  initial begin
    #1 rst_n = 0;
    #3;
    chk("rst_rdata", rdata, 0);
    chk("rst_out_valid", uart_out_valid, 0);
    chk("rst_in_valid", uart_in_valid, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    rd(BASE + 8, 64'h2);
    rd(BASE + 24, 64'h1);
    rd(BASE + 64'h1F, 64'h1);
    rd(BASE, 64'h0);
    wr(0, 64'h99, 8'hFE);
    wr(0, 64'h41); pushc(8'h41, cyc + 1);
    wr(0, 64'h42); pushc(8'h42, cyc + 1);
    idle();
    rd(BASE + 8, 64'h2);
    idle();
    wr(3, 0);
    for (int i = 0; i < 9; i++) wr(0, 64'h30 + 64'(i));
    rd(BASE + 8, 64'h805);
    wr(3, 1);
    c = cyc;
    for (int i = 0; i < 8; i++) pushc(8'h30 + 8'(i), c + 1 + i);
    idle();
    repeat (10) @(posedge clk);
    rd(BASE + 64'h40, 64'h0);
    #1 chk("miss_in_valid", uart_in_valid, 0);
    rd(BASE + 8, 64'h6);
    wr(1, 64'h4);
    rd(BASE + 8, 64'h2);
    idle();
    wr(3, 0);
    for (int i = 0; i < 8; i++) wr(0, 64'h50 + 64'(i));
    wr(3, 1);
    c = cyc;
    for (int i = 0; i < 8; i++) pushc(8'h50 + 8'(i), c + 1 + i);
    wr(0, 64'h55); pushc(8'h55, c + 9);
    rd(BASE + 8, 64'h801);
    idle();
    repeat (12) @(posedge clk);
    rd(BASE + 8, 64'h2);
    rd(BASE + 16, 64'h61);
    uart_in_ch = 8'h61;
    #1 chk("rx_in_valid", uart_in_valid, 1);
    rd(BASE + 16, 64'hFF);
    uart_in_ch = 8'hFF;
    #1 chk("rx_in_valid_ff", uart_in_valid, 1);
    idle();
    #1 chk("idle_in_valid", uart_in_valid, 0);
    wr(3, 0);
    wr(0, 64'h71);
    wr(0, 64'h72);
    wr(0, 64'h73);
    rd(BASE + 8, 64'h300);
    wr(3, 1);
    pushc(8'h71, cyc + 1);
    idle();
    @(negedge clk);
    #1 rst_n = 0;
    #1;
    chk("mid_rst_out_valid", uart_out_valid, 0);
    chk("mid_rst_rdata", rdata, 0);
    chk("mid_rst_in_valid", uart_in_valid, 0);
    @(posedge clk);
    #1 rst_n = 1;
    rd(BASE + 8, 64'h2);
    rd(BASE + 24, 64'h1);
    idle();
    repeat (12) @(posedge clk);
    chk("tx_left", exp_ch.size(), 0);
    chk("rd_left", exp_rd.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/uart_mmio.md
UART_MMIO -- requirements
Module: uart_mmio

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 64'h0000_0000_1000_0000, device base address (32-byte aligned).
REQ-002 SHALL have parameter TX_DEPTH, default 8, TX FIFO entries (power of 2, 2..64).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port en  input  1  access request, sram-style initiator side.
REQ-006 SHALL have port we  input  8  byte write enables; 0 means read.
REQ-007 SHALL have port addr  input  64  byte address.
REQ-008 SHALL have port wdata  input  64  write data.
REQ-009 SHALL have port rdata  output  64  read data.
REQ-010 SHALL have port uart_out_valid  output  1  character emitted this cycle.
REQ-011 SHALL have port uart_out_ch  output  8  emitted character.
REQ-012 SHALL have port uart_in_valid  output  1  character request strobe.
REQ-013 SHALL have port uart_in_ch  input  8  character returned by host in the same cycle; 8'hFF means none.

Function
REQ-014 SHALL decode hit = en & (addr[63:5] == BASE_ADDR[63:5]) and offset = addr[4:3].
REQ-015 SHALL ignore addr[2:0].
REQ-016 SHALL provide register map: offset 0 TXDATA (W); offset 1 STATUS (R/W1C); offset 2 RXDATA (R); offset 3 CTRL (R/W).
REQ-017 SHALL define STATUS as [0] tx_full, [1] tx_empty, [2] overflow (sticky), [15:8] tx_count; all other bits 0.
REQ-018 SHALL define CTRL as [0] tx_en, reset value 1; all other bits read 0.
REQ-019 SHALL use read latency of exactly 1 cycle: rdata registered on the edge after a hit read; rdata holds its value when no read is in progress.
REQ-020 SHALL return 64'h0 on the next cycle for a read miss with en=1 and we=0.
REQ-021 SHALL return 0 for a TXDATA read.
REQ-022 SHALL push wdata[7:0] into the TX FIFO on a TXDATA write with we[0]=1; a write with we[0]=0 has no effect.
REQ-023 SHALL clear overflow on a STATUS write with we[0]=1 and wdata[2]=1.
REQ-024 SHALL set tx_en = wdata[0] on a CTRL write with we[0]=1.
REQ-025 SHALL drain the TX FIFO when tx_en=1 and FIFO non-empty: pop one entry per cycle, combinationally driving uart_out_valid=1 and uart_out_ch=head.
REQ-026 SHALL otherwise drive uart_out_valid=0 and uart_out_ch=0.
REQ-027 SHALL, on push to a full FIFO in a cycle with no pop, drop the byte, set overflow, and leave count unchanged.
REQ-028 SHALL, on push to a full FIFO in the same cycle as a pop, accept the push; count stays TX_DEPTH and overflow is not set.
REQ-029 SHALL, on simultaneous push and pop at a non-full, non-empty FIFO, keep count unchanged.
REQ-030 SHALL make a push into an empty FIFO visible no earlier than the next cycle (no write-through).
REQ-031 SHALL wrap read and write pointers modulo TX_DEPTH; count is $clog2(TX_DEPTH)+1 bits.
REQ-032 SHALL assert uart_in_valid combinationally on an RXDATA hit read in the same cycle, sample uart_in_ch that cycle, and return {56'h0, uart_in_ch} on rdata next cycle; 8'hFF is passed through unchanged.
REQ-033 SHALL hold uart_in_valid at 0 at all other times.
REQ-034 SHALL treat a STATUS read as reflecting state before the current cycle's push/pop.

Reset
REQ-035 SHALL, on rst_n low, immediately and asynchronously set rdata=0, FIFO empty (pointers 0, count 0), overflow=0, tx_en=1, uart_out_valid=0, uart_in_valid=0.
REQ-036 SHALL discard queued bytes when reset is asserted mid-drain, with no output for them after release.

Verification
REQ-037 SHALL verify: write TXDATA wdata=0x41 then 0x42 on consecutive cycles -> uart_out_valid on cycles +1 and +2 with ch 0x41, 0x42; STATUS read afterwards returns 0x2.
REQ-038 SHALL verify: CTRL=0, write 9 bytes 0x30..0x38 with TX_DEPTH=8 -> STATUS=0x0805 (count 8, full, overflow); CTRL=1 -> 0x30..0x37 emitted on 8 consecutive cycles, 0x38 never emitted.
REQ-039 SHALL verify: with FIFO full and tx_en=1, push 0x55 in the pop cycle -> accepted, overflow stays 0, 0x55 is emitted last.
REQ-040 SHALL verify: RXDATA read with uart_in_ch=0x61 -> uart_in_valid=1 in the same cycle, rdata=0x61 next cycle; with uart_in_ch=0xFF -> rdata=0xFF.
REQ-041 SHALL verify: read addr=BASE_ADDR+0x40 -> rdata=0 and no uart_in_valid; write STATUS wdata=0x4 clears overflow -> STATUS bit2=0.
REQ-042 SHALL verify: rst_n low for 1 cycle while 3 bytes are queued -> uart_out_valid=0 immediately, STATUS=0x2, and no stale bytes after release.
